// File: rtl/enc8to3_arb.sv
// ---------------------------------------------------------------------------
// enc8to3_arb -- pending-request 8-to-3 priority encoder with a valid/ready
// presentation handshake.
//
// Each request pulse on din sets a sticky pending bit. While the block is
// idle, the highest-priority pending and unmasked index is loaded into dout
// and presented with valid=1. The presented index stays frozen until the
// consumer accepts it (valid && ready). Acceptance clears that pending bit
// and forces a one-cycle bubble before the next index is presented.
//
// Parameters:
//   LOW_FIRST  0: bit 7 has the highest priority; 1: bit 0 has the highest.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   din      in   [7:0] request pulses, one bit per index
//   mask     in   [7:0] arbitration enable per index (masked bits stay pending)
//   dout     out  [2:0] index being presented
//   valid    out  dout holds a presented request
//   ready    in   consumer accepts the presented request
//   pend     out  [7:0] pending register
//   ovf      out  sticky: a request arrived for an index already pending
//   ovf_clr  in   synchronous clear of ovf (a same-edge set wins)
// ---------------------------------------------------------------------------
module enc8to3_arb #(
  parameter int unsigned LOW_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] mask,
  output logic [2:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pend,
  output logic       ovf,
  input  logic       ovf_clr
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pend;
  logic [7:0] w_pend_nxt;
  logic [2:0] r_dout;
  logic [2:0] w_dout_nxt;
  logic       r_ovf;
  logic       w_ovf_nxt;

  logic       w_grant;
  logic [7:0] w_clr;
  logic [7:0] w_dup;
  logic [7:0] w_cand;
  logic       w_any;
  logic [2:0] w_sel;

  // Arbitration only ever looks at the registered pending bits.
  always_comb begin
    w_cand = r_pend & mask;
    w_any  = |w_cand;
  end

  // Fixed-order priority encoder; the last match in the scan wins, so the
  // scan direction is the reverse of the priority order.
  always_comb begin
    w_sel = '0;
    if (LOW_FIRST != 0) begin
      for (int unsigned i = 8; i > 0; i--) begin
        if (w_cand[i-1]) w_sel = 3'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (w_cand[i]) w_sel = 3'(i);
      end
    end
  end

  // Pending and overflow update. A bit being granted this edge is removed
  // before din is merged in, so a same-cycle repeat keeps it set without
  // counting as an overflow.
  always_comb begin
    w_grant = (r_state == ST_PRESENT) && ready;
    w_clr   = '0;
    if (w_grant) w_clr[r_dout] = 1'b1;
    w_dup      = din & r_pend & ~w_clr;
    w_pend_nxt = (r_pend & ~w_clr) | din;
    w_ovf_nxt  = r_ovf;
    if (|w_dup) begin
      w_ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      w_ovf_nxt = 1'b0;
    end
  end

  // Presentation FSM next state. Returning to IDLE on acceptance is what
  // produces the one-cycle bubble between consecutive grants.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_PRESENT;
          w_dout_nxt  = w_sel;
        end
      end
      ST_PRESENT: begin
        if (ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_dout  <= w_dout_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign dout  = r_dout;
  assign valid = (r_state == ST_PRESENT);
  assign pend  = r_pend;
  assign ovf   = r_ovf;

endmodule
